// File: rtl/hdd_multi_ctrl.sv
// -----------------------------------------------------------------------------
// hdd_multi_ctrl
//   Multi-unit mounted-image block device controller. The CPU sees a 16-byte
//   register window. The host sees a block request/acknowledge handshake and a
//   second port into the shared sector buffer.
//
// Ports
//   CLK_14M, RESET     system clock, asynchronous active-high reset
//   phi0               bus phase qualifier
//   DEVICE_SELECT      register window select
//   A, RD, D_IN        register offset, 1=read/0=write, write data
//   D_OUT              read data; 0xFF when the window is not being read
//   sector, unit_sel   block number and unit index presented to the host
//   blk_read/blk_write level requests, high while a transfer is pending
//   blk_ack, blk_err   host completion pulse and its error flag
//   hdd_mounted/protect per-unit mounted and write-protect flags
//   ram_addr/di/do/we  host port into the sector buffer (1-cycle read latency)
//   busy               a command is in flight
// -----------------------------------------------------------------------------
module hdd_multi_ctrl #(
  parameter int NUM_UNITS      = 2,
  parameter int BLOCK_BYTES    = 512,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                           CLK_14M,
  input  logic                           RESET,
  input  logic                           phi0,
  input  logic                           DEVICE_SELECT,
  input  logic [3:0]                     A,
  input  logic                           RD,
  input  logic [7:0]                     D_IN,
  output logic [7:0]                     D_OUT,
  output logic [15:0]                    sector,
  output logic [2:0]                     unit_sel,
  output logic                           blk_read,
  output logic                           blk_write,
  input  logic                           blk_ack,
  input  logic                           blk_err,
  input  logic [NUM_UNITS-1:0]           hdd_mounted,
  input  logic [NUM_UNITS-1:0]           hdd_protect,
  input  logic [$clog2(BLOCK_BYTES)-1:0] ram_addr,
  input  logic [7:0]                     ram_di,
  output logic [7:0]                     ram_do,
  input  logic                           ram_we,
  output logic                           busy
);

  localparam int AW = $clog2(BLOCK_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_IO_ERR = 8'h27;
  localparam logic [7:0] ST_NO_DEV = 8'h28;
  localparam logic [7:0] ST_WP     = 8'h2B;
  localparam logic [7:0] ST_BUSY   = 8'h80;

  typedef enum logic [1:0] {IDLE, WAIT_RD, WAIT_WR} state_t;

  state_t          state;
  logic [7:0]      reg_status, reg_cmd, reg_unit;
  logic [7:0]      reg_mem_l, reg_mem_h, reg_blk_l, reg_blk_h;
  logic [AW-1:0]   ptr;
  logic [TW-1:0]   timer;
  logic            armed;
  logic [7:0]      cpu_byte;
  logic [7:0]      mem [BLOCK_BYTES];

  logic            strobe, cpu_rd, cpu_wr, is_busy;
  logic            buf_cpu_we, buf_cpu_rd;
  logic [2:0]      unit_idx;
  logic [7:0]      mounted_ext, protect_ext;
  logic            unit_ok, unit_wp;

  // One side effect per access: armed while the window is deselected, spent
  // on the first phi0 cycle of the following selection.
  assign strobe  = armed & phi0 & DEVICE_SELECT;
  assign cpu_rd  = strobe & RD;
  assign cpu_wr  = strobe & ~RD;
  assign is_busy = (state != IDLE);
  assign busy    = is_busy;

  assign buf_cpu_we = cpu_wr & (A == 4'h8) & ~is_busy;
  assign buf_cpu_rd = cpu_rd & (A == 4'h8);

  // Zero-extending to 8 bits makes any index >= NUM_UNITS read as unmounted.
  assign unit_idx    = reg_unit[6:4];
  assign mounted_ext = 8'(hdd_mounted);
  assign protect_ext = 8'(hdd_protect);
  assign unit_ok     = mounted_ext[unit_idx];
  assign unit_wp     = protect_ext[unit_idx];

  assign unit_sel = unit_idx;
  assign sector   = {reg_blk_h, reg_blk_l};

  // NOTE: the sector buffer carries no reset so it maps onto block RAM and
  // keeps its contents across RESET; the host write comes last so it wins a
  // same-address collision with the CPU.
  always_ff @(posedge CLK_14M) begin
    if (buf_cpu_we) mem[ptr] <= D_IN;
    if (ram_we)     mem[ram_addr] <= ram_di;
    ram_do <= mem[ram_addr];
  end

  // NOTE: every register here uses non-blocking assignment so all updates
  // see the pre-edge values, regardless of statement order.
  always_ff @(posedge CLK_14M or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      reg_status <= 8'h00;
      reg_cmd    <= 8'h00;
      reg_unit   <= 8'h00;
      reg_mem_l  <= 8'h00;
      reg_mem_h  <= 8'h00;
      reg_blk_l  <= 8'h00;
      reg_blk_h  <= 8'h00;
      ptr        <= '0;
      timer      <= '0;
      armed      <= 1'b0;
      cpu_byte   <= 8'h00;
      blk_read   <= 1'b0;
      blk_write  <= 1'b0;
    end else begin
      if (!DEVICE_SELECT) armed <= 1'b1;
      else if (phi0)      armed <= 1'b0;

      // Status stays writable while busy; everything else is frozen.
      if (cpu_wr) begin
        if (A == 4'h1) begin
          reg_status <= D_IN;
        end else if (!is_busy) begin
          case (A)
            4'h2: begin
              reg_cmd <= D_IN;
              if (D_IN == 8'h02) ptr <= '0;
            end
            4'h3: reg_unit  <= D_IN;
            4'h4: reg_mem_l <= D_IN;
            4'h5: reg_mem_h <= D_IN;
            4'h6: reg_blk_l <= D_IN;
            4'h7: reg_blk_h <= D_IN;
            4'h8: ptr       <= ptr + 1'b1;
            default: ;
          endcase
        end
      end

      if (buf_cpu_rd) begin
        cpu_byte <= mem[ptr];
        ptr      <= ptr + 1'b1;
      end

      // Completion is evaluated after the bus writes so it overrides a
      // coincident status write.
      case (state)
        IDLE: begin
          if (cpu_rd && A == 4'h0) begin
            ptr <= '0;
            if (!unit_ok) begin
              reg_status <= ST_NO_DEV;
            end else begin
              case (reg_cmd)
                8'h01: begin
                  state    <= WAIT_RD;
                  blk_read <= 1'b1;
                  timer    <= '0;
                end
                8'h02: begin
                  if (unit_wp) begin
                    reg_status <= ST_WP;
                  end else begin
                    state     <= WAIT_WR;
                    blk_write <= 1'b1;
                    timer     <= '0;
                  end
                end
                default: reg_status <= ST_OK;
              endcase
            end
          end
        end
        WAIT_RD, WAIT_WR: begin
          if (blk_ack) begin
            state      <= IDLE;
            blk_read   <= 1'b0;
            blk_write  <= 1'b0;
            reg_status <= blk_err ? ST_IO_ERR : ST_OK;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state      <= IDLE;
            blk_read   <= 1'b0;
            blk_write  <= 1'b0;
            reg_status <= ST_IO_ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          blk_read  <= 1'b0;
          blk_write <= 1'b0;
        end
      endcase
    end
  end

  // Offsets 0 and 1 both report busy as 0x80 so a polling CPU never sees a
  // stale completion code.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves D_OUT
    // unassigned and a latch is never inferred.
    D_OUT = 8'hFF;
    if (DEVICE_SELECT && RD && !RESET) begin
      case (A)
        4'h0, 4'h1: D_OUT = is_busy ? ST_BUSY : reg_status;
        4'h2:       D_OUT = reg_cmd;
        4'h3:       D_OUT = reg_unit;
        4'h4:       D_OUT = reg_mem_l;
        4'h5:       D_OUT = reg_mem_h;
        4'h6:       D_OUT = reg_blk_l;
        4'h7:       D_OUT = reg_blk_h;
        4'h8:       D_OUT = cpu_byte;
        default:    D_OUT = 8'hFF;
      endcase
    end
  end

endmodule

// File: doc/hdd_multi_ctrl.md
HDD_MULTI_CTRL -- requirements
Module: hdd_multi_ctrl

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 2, number of mounted-image units (1..8).
REQ-002 SHALL have parameter BLOCK_BYTES, default 512, sector buffer depth (power of two, 256..4096).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1048576, CLK_14M cycles to wait for host ack.
REQ-004 SHALL use one clock, CLK_14M; reset RESET is asynchronous and active-high.
REQ-005 Ports (name  direction  width  meaning):
CLK_14M  in  1  system clock
RESET  in  1  async active-high reset
phi0  in  1  bus phase qualifier
DEVICE_SELECT  in  1  register window select
A  in  4  register offset
RD  in  1  1=CPU read, 0=CPU write
D_IN  in  8  CPU write data
D_OUT  out  8  CPU read data
sector  out  16  block number to host
unit_sel  out  3  unit index to host
blk_read  out  1  host read request, level
blk_write  out  1  host write request, level
blk_ack  in  1  host completion pulse
blk_err  in  1  host error, valid with blk_ack
hdd_mounted  in  NUM_UNITS  per-unit mounted
hdd_protect  in  NUM_UNITS  per-unit write protect
ram_addr  in  log2(BLOCK_BYTES)  host buffer address
ram_di  in  8  host buffer write data
ram_do  out  8  host buffer read data, 1-cycle latency
ram_we  in  1  host buffer write enable
busy  out  1  command in flight

Function
REQ-006 Register offsets: 0 execute/return status (r); 1 status (r/w); 2 command (r/w); 3 unit (r/w); 4/5 mem L/H (r/w); 6/7 block L/H (r/w); 8 next buffer byte (r/w); 9-F read 0xFF, writes ignored.
REQ-007 Bus side effects SHALL occur once per access: on the first CLK_14M cycle with phi0=1 and DEVICE_SELECT=1 after DEVICE_SELECT was 0.
REQ-008 D_OUT SHALL reflect the addressed register whenever DEVICE_SELECT=1 and RD=1; else 0xFF.
REQ-009 Unit index = reg_unit[6:4]; unit_sel SHALL equal it; sector = {block_h, block_l}.
REQ-010 FSM states IDLE, WAIT_RD, WAIT_WR.
REQ-011 Offset-0 read in IDLE: index >= NUM_UNITS or unmounted -> status 0x28; command 0 (status) -> 0x00; command 1 -> WAIT_RD; command 2 with protect -> 0x2B; command 2 otherwise -> WAIT_WR; command 3 (format) and other values -> 0x00, no request. Buffer pointer SHALL reset to 0.
REQ-012 blk_read/blk_write SHALL be high exactly while in WAIT_RD/WAIT_WR; busy = state != IDLE.
REQ-013 In WAIT_*: blk_ack=1 -> IDLE, status 0x00 if blk_err=0 else 0x27; timeout counter reaching TIMEOUT_CYCLES -> IDLE, status 0x27.
REQ-014 Offset-0 or offset-1 read while busy SHALL return 0x80; status register unchanged; no new command.
REQ-015 Writes to offsets 2-8 while busy SHALL be ignored.
REQ-016 Offset-8 read returns buf[ptr], then ptr+1; offset-8 write stores D_IN at buf[ptr], then ptr+1; ptr wraps BLOCK_BYTES-1 -> 0.
REQ-017 Writing 0x02 to offset 2 SHALL reset ptr to 0.
REQ-018 Host port: ram_we=1 writes buf[ram_addr]; ram_do = buf[ram_addr] registered.
REQ-019 Same-cycle CPU and host write to the same address: host data SHALL win.
REQ-020 Offset-1 write SHALL load status directly (read-modify-write support).

Reset
REQ-021 RESET SHALL force IDLE, all registers 0x00, ptr 0, timeout counter 0, blk_read=blk_write=busy=0, D_OUT=0xFF; buffer contents not cleared.
REQ-022 RESET mid-command SHALL drop requests immediately; a later blk_ack in IDLE SHALL be ignored.

Verification
REQ-023 Unit 0 mounted, cmd 1, block 0x0123, offset-0 read -> blk_read=1, sector=0x0123; ack 5 cycles later -> blk_read=0, offset-1 reads 0x00.
REQ-024 Unit 1 protected, cmd 2, offset-0 read -> status 0x2B, blk_write never asserted.
REQ-025 reg_unit=0x50 with NUM_UNITS=2 -> offset-0 read gives 0x28.
REQ-026 Host writes buf[0..511]=i[7:0]; 513 offset-8 reads -> 0x00..0xFF twice, then 0x00 (wrap).
REQ-027 TIMEOUT_CYCLES=16, cmd 1, no ack -> busy for 16 cycles, then status 0x27; offset-0 read while busy -> 0x80.
REQ-028 RESET during WAIT_WR, then blk_ack -> state IDLE, status 0x00, no requests.
